// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI burst sequencer.
// State encoding plus default chip-select timing.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_GO    = 3'd3,
    ST_XFER  = 3'd4,
    ST_RXOUT = 3'd5,
    ST_GAP   = 3'd6,
    ST_HOLD  = 3'd7
  } state_t;

  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;

  // Counter preload so a wait of n cycles ends when the counter reads zero.
  function automatic logic [7:0] cnt_preload(input int n);
    logic [7:0] v;
    v = (n <= 0) ? 8'd0 : 8'(n - 1);
    return v;
  endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// 8-bit loadable down-counter with zero flag.
// Shared by the setup, gap and hold waits.
module spi_delay_cnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI burst sequencer around a byte-wide SPI master.
// Owns chip select and streams TX/RX bytes over valid/ready.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int LEN_W    = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             cfg_cspol,
  input  logic [7:0]       cfg_gap,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             spi_go,
  output logic [7:0]       spi_data_o,
  input  logic             spi_state,
  input  logic [7:0]       spi_data_i,
  output logic             cs
);

  localparam logic [7:0] SETUP_LD = cnt_preload(CS_SETUP);
  localparam logic [7:0] HOLD_LD  = cnt_preload(CS_HOLD);
  localparam bit SETUP_NONE = (CS_SETUP == 0);
  localparam bit HOLD_NONE  = (CS_HOLD == 0);

  state_t           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       gap_q;
  logic             abort_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             go_q;
  logic [7:0]       sdo_q;
  logic [7:0]       rxd_q;
  logic             rxv_q;
  logic             cs_q;
  logic             rel_q;

  logic       cnt_ld;
  logic [7:0] cnt_val;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       rx_hs;
  logic       last;
  logic       to_hold;

  assign tx_ready = (state_q == ST_FETCH) && tx_valid && !abort;
  assign rx_hs    = (state_q == ST_RXOUT) && rx_ready;
  assign last     = (rem_q == '0) || abort_q || abort;

  always_comb begin
    to_hold = 1'b0;
    unique case (1'b1)
      (state_q == ST_SETUP): to_hold = abort;
      (state_q == ST_FETCH): to_hold = abort;
      (state_q == ST_GAP):   to_hold = abort;
      (state_q == ST_RXOUT): to_hold = rx_hs && last;
      default:               to_hold = 1'b0;
    endcase
  end

  always_comb begin
    cnt_ld  = 1'b0;
    cnt_val = 8'd0;
    cnt_dec = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_ld  = start && !SETUP_NONE;
        cnt_val = SETUP_LD;
      end
      ST_SETUP: cnt_dec = 1'b1;
      ST_GAP:   cnt_dec = 1'b1;
      ST_RXOUT: begin
        cnt_ld  = rx_hs && !last && (gap_q != 8'd0);
        cnt_val = gap_q - 8'd1;
      end
      ST_HOLD: cnt_dec = !rel_q;
      default: cnt_dec = 1'b0;
    endcase
    // Entering HOLD reuses the counter for the CS hold time.
    if (to_hold) begin
      cnt_ld  = !HOLD_NONE;
      cnt_val = HOLD_LD;
    end
  end

  spi_delay_cnt u_dly (
    .clk_i  (clkin),
    .rst_ni (rst_n),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      gap_q     <= 8'd0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      go_q      <= 1'b0;
      sdo_q     <= 8'd0;
      rxd_q     <= 8'd0;
      rxv_q     <= 1'b0;
      cs_q      <= cfg_cspol;
      rel_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if ((state_q != ST_IDLE) && abort) begin
        abort_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          cs_q <= cfg_cspol;
          if (start) begin
            rem_q   <= len;
            gap_q   <= cfg_gap;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            cs_q    <= ~cfg_cspol;
            state_q <= SETUP_NONE ? ST_FETCH : ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (tx_ready) begin
            sdo_q   <= tx_data;
            go_q    <= 1'b1;
            state_q <= ST_GO;
          end
        end
        ST_GO: begin
          if (spi_state) begin
            go_q    <= 1'b0;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!spi_state) begin
            rxd_q   <= spi_data_i;
            rxv_q   <= 1'b1;
            state_q <= ST_RXOUT;
          end
        end
        ST_RXOUT: begin
          if (rx_hs) begin
            rxv_q <= 1'b0;
            if (!last) begin
              rem_q   <= rem_q - LEN_W'(1);
              state_q <= (gap_q == 8'd0) ? ST_FETCH : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt_zero) state_q <= ST_FETCH;
        end
        ST_HOLD: begin
          if (!rel_q) begin
            if (cnt_zero) begin
              cs_q  <= cfg_cspol;
              rel_q <= 1'b1;
            end
          end else begin
            done_q    <= 1'b1;
            aborted_q <= abort_q;
            busy_q    <= 1'b0;
            rel_q     <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (to_hold) begin
        state_q <= ST_HOLD;
        rel_q   <= HOLD_NONE;
        if (HOLD_NONE) cs_q <= cfg_cspol;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign rx_data    = rxd_q;
  assign rx_valid   = rxv_q;
  assign spi_go     = go_q;
  assign spi_data_o = sdo_q;
  assign cs         = cs_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl with a behavioural
// SPI master model and transaction-level expectations.
module tb_spi_burst_ctrl;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_cspol = 1'b1;
  logic [7:0] cfg_gap = 8'd0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       abort = 1'b0;
  logic       busy, done, aborted;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       spi_go;
  logic [7:0] spi_data_o;
  logic       spi_state = 1'b0;
  logic [7:0] spi_data_i = 8'd0;
  logic       cs;

  always #5 clkin = ~clkin;

  spi_burst_ctrl #(
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .LEN_W(8)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .cfg_cspol(cfg_cspol),
    .cfg_gap(cfg_gap), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_go(spi_go), .spi_data_o(spi_data_o),
    .spi_state(spi_state), .spi_data_i(spi_data_i), .cs(cs)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stimulus controls, written only by the main sequence.
  logic [7:0] txsrc[$];
  logic [7:0] key = 8'd0;
  bit tx_en = 0, rx_en = 0, rnd = 0;
  int b_tx, b_rx, b_go, b_fall, b_cs, b_done;

  // Log written only by the monitor.
  int cyc = 0, txcnt = 0, gocnt = 0, go_viol = 0, stab_viol = 0;
  int cs_asserts = 0, cs_a_cyc = 0, cs_r_cyc = 0;
  int done_cnt = 0, done_cyc = 0, rx_hs_cyc = 0;
  logic done_ab = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] godq[$];
  int goq[$];
  int fallq[$];

  // SPI master model: goes busy 1..3 cycles after go, stays busy
  // 3..7 cycles, returns the byte XOR key.
  initial begin
    int st, d, k;
    logic [7:0] b;
    st = 0; d = 0; k = 0; b = 8'd0;
    forever begin
      @(posedge clkin);
      #1;
      if (!rst_n) begin
        st = 0;
        spi_state = 1'b0;
      end else if (st == 0) begin
        if (spi_go) begin
          b = spi_data_o;
          d = $urandom_range(0, 2);
          st = 1;
        end
      end else if (st == 1) begin
        if (d == 0) begin
          spi_state = 1'b1;
          k = $urandom_range(2, 6);
          st = 2;
        end else d--;
      end else begin
        if (k == 0) begin
          spi_state = 1'b0;
          spi_data_i = b ^ key;
          st = 0;
        end else k--;
      end
    end
  end

  // TX source and RX sink drivers.
  initial begin
    int ti;
    forever begin
      @(posedge clkin);
      #1;
      ti = txcnt - b_tx;
      tx_valid = tx_en && (ti < txsrc.size()) &&
                 (!rnd || ($urandom_range(0, 1) == 1));
      tx_data = (ti < txsrc.size()) ? txsrc[ti] : 8'h00;
      rx_ready = rx_en && (!rnd || ($urandom_range(0, 2) != 0));
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    logic p_go, p_st, p_cs, p_rxv, p_rxr;
    logic [7:0] p_rxd;
    p_go = 0; p_st = 0; p_cs = 1; p_rxv = 0; p_rxr = 0; p_rxd = 0;
    forever begin
      @(negedge clkin);
      cyc++;
      if (rst_n) begin
        if (tx_valid && tx_ready) txcnt++;
        if (rx_valid && rx_ready) begin
          rxq.push_back(rx_data);
          rx_hs_cyc = cyc;
        end
        if (rx_valid && p_rxv && !p_rxr && (rx_data !== p_rxd))
          stab_viol++;
        if (spi_go && !p_go) begin
          gocnt++;
          goq.push_back(cyc);
          godq.push_back(spi_data_o);
        end
        if (spi_go && p_st) go_viol++;
        if (!spi_state && p_st) fallq.push_back(cyc);
        if ((cs != cfg_cspol) && (p_cs == cfg_cspol)) begin
          cs_asserts++;
          cs_a_cyc = cyc;
        end
        if ((cs == cfg_cspol) && (p_cs != cfg_cspol)) cs_r_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          done_ab = aborted;
        end
      end
      p_go = spi_go; p_st = spi_state; p_cs = cs;
      p_rxv = rx_valid; p_rxr = rx_ready; p_rxd = rx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic snap();
    b_tx = txcnt; b_rx = rxq.size(); b_go = gocnt;
    b_fall = fallq.size(); b_cs = cs_asserts; b_done = done_cnt;
  endtask

  task automatic load(input int n, input bit r);
    txsrc.delete();
    for (int i = 0; i < n; i++) txsrc.push_back(8'($urandom));
    rnd = r;
    snap();
  endtask

  task automatic go_burst(input int l, input int g, input logic ab);
    start = 1'b1; len = 8'(l); cfg_gap = 8'(g); abort = ab;
    tick(1);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    for (int i = 0; i < lim && done_cnt == b_done; i++) tick(1);
    chk(tag, done_cnt - b_done, 1);
    tick(2);
  endtask

  task automatic chk_rx(input string tag, input int n);
    int bad;
    bad = 0;
    chk({tag, "_rxcnt"}, rxq.size() - b_rx, n);
    for (int i = 0; i < n; i++)
      if ((b_rx + i >= rxq.size()) ||
          (rxq[b_rx + i] !== (txsrc[i] ^ key))) bad++;
    chk({tag, "_rxdata"}, bad, 0);
  endtask

  initial begin
    int n, g;
    // Reset with CS idle high.
    rst_n = 1'b0; cfg_cspol = 1'b1;
    tick(3);
    chk("rst_cs", cs, 1);
    chk("rst_busy", busy, 0);
    chk("rst_go", spi_go, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_sdo", spi_data_o, 0);
    rst_n = 1'b1; tx_en = 1; rx_en = 1; key = 8'h00;
    tick(3);
    chk("idle_done", done_cnt, 0);
    chk("idle_busy", busy, 0);

    // Single byte, loopback.
    load(1, 0); txsrc[0] = 8'hA5;
    go_burst(0, 0, 1'b0);
    chk("b1_busy", busy, 1);
    wait_done(100, "b1_done");
    chk("b1_txcnt", txcnt - b_tx, 1);
    chk("b1_sdo", godq[b_go], 8'hA5);
    chk("b1_setup", goq[b_go] - cs_a_cyc, CS_SETUP + 1);
    chk_rx("b1", 1);
    chk("b1_hold", cs_r_cyc - rx_hs_cyc, CS_HOLD + 1);
    chk("b1_donepos", done_cyc - cs_r_cyc, 1);
    chk("b1_aborted", done_ab, 0);
    chk("b1_busy_end", busy, 0);

    // Three bytes with a 4-cycle gap.
    load(3, 0); txsrc[0] = 8'h01; txsrc[1] = 8'h02; txsrc[2] = 8'h03;
    go_burst(2, 4, 1'b0);
    wait_done(200, "b3_done");
    chk_rx("b3", 3);
    chk("b3_cs", cs_asserts - b_cs, 1);
    for (int i = 1; i < 3; i++)
      chk("b3_gap", goq[b_go + i] - fallq[b_fall + i - 1], 4 + 3);

    // Flow control stalls on both sides.
    load(3, 0);
    go_burst(2, 0, 1'b0);
    for (int i = 0; i < 40 && (txcnt - b_tx) < 1; i++) tick(1);
    tx_en = 0;
    for (int i = 0; i < 40 && (rxq.size() - b_rx) < 1; i++) tick(1);
    chk("fc_rx0", rxq.size() - b_rx, 1);
    tick(10);
    chk("fc_txstall_go", gocnt - b_go, 1);
    chk("fc_txstall_tx", txcnt - b_tx, 1);
    rx_en = 0; tx_en = 1;
    tick(25);
    chk("fc_rxstall_rx", rxq.size() - b_rx, 1);
    chk("fc_rxstall_go", gocnt - b_go, 2);
    chk("fc_rxv_held", rx_valid, 1);
    rx_en = 1;
    wait_done(200, "fc_done");
    chk_rx("fc", 3);

    // Abort during byte 2 transfer.
    load(5, 0);
    go_burst(4, 0, 1'b0);
    for (int i = 0; i < 100 && !((gocnt - b_go) == 2 && spi_state); i++)
      tick(1);
    chk("ab_reach", ((gocnt - b_go) == 2) && spi_state, 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    wait_done(100, "ab_done");
    chk_rx("ab", 2);
    chk("ab_txcnt", txcnt - b_tx, 2);
    chk("ab_aborted", done_ab, 1);
    chk("ab_hold", cs_r_cyc - rx_hs_cyc, CS_HOLD + 1);

    // Abort in IDLE ignored; start with abort accepted clean.
    abort = 1'b1; tick(1); abort = 1'b0; tick(2);
    load(1, 0);
    go_burst(0, 0, 1'b1);
    wait_done(100, "sa_done");
    chk("sa_aborted", done_ab, 0);
    chk_rx("sa", 1);

    // Start while busy ignored.
    load(6, 0);
    go_burst(1, 0, 1'b0);
    tick(3);
    go_burst(5, 0, 1'b0);
    wait_done(200, "sb_done");
    chk("sb_txcnt", txcnt - b_tx, 2);
    chk_rx("sb", 2);
    tick(20);
    chk("sb_nomore", done_cnt - b_done, 1);

    // Longest burst, random data through a non-trivial transform.
    key = 8'($urandom);
    load(256, 0);
    go_burst(255, 0, 1'b0);
    wait_done(6000, "max_done");
    chk("max_txcnt", txcnt - b_tx, 256);
    chk_rx("max", 256);
    chk("max_cs", cs_asserts - b_cs, 1);

    // Randomised bursts with random stalls and CS polarity.
    for (int it = 0; it < 8; it++) begin
      cfg_cspol = 1'($urandom_range(0, 1));
      tick(3);
      key = 8'($urandom);
      n = $urandom_range(1, 7);
      g = $urandom_range(0, 3);
      load(n, 1);
      go_burst(n - 1, g, 1'b0);
      wait_done(600, "rnd_done");
      chk("rnd_txcnt", txcnt - b_tx, n);
      chk_rx("rnd", n);
      chk("rnd_cs", cs_asserts - b_cs, 1);
      chk("rnd_aborted", done_ab, 0);
    end

    // Reset in the middle of a transfer.
    load(4, 0);
    go_burst(3, 0, 1'b0);
    for (int i = 0; i < 100 && !spi_state; i++) tick(1);
    chk("mr_reach", spi_state, 1);
    rst_n = 1'b0;
    @(posedge clkin);
    @(negedge clkin);
    chk("mr_cs", cs, cfg_cspol);
    chk("mr_busy", busy, 0);
    chk("mr_rxv", rx_valid, 0);
    chk("mr_go", spi_go, 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    chk("go_protocol", go_viol, 0);
    chk("rx_stable", stab_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
